// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, valid/ready on both ports.
// Optional rotate-right datapath for mode 11 is enabled by defining ROTATE_EN.
module barrel_shifter_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
   input  logic [SHW-1:0]   sel,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out
);

   typedef enum logic [1:0] {
      MODE_SRL = 2'b00,
      MODE_SRA = 2'b01,
      MODE_SLL = 2'b10,
      MODE_ROR = 2'b11
   } mode_e;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   sel;
      mode_e            mode;
      logic             sign;
   } payload_t;

   logic [SHW-1:0] valid_q;
   payload_t       pay_q [SHW];
   payload_t       pay_d [SHW];
   payload_t       src   [SHW];
   logic [SHW-1:0] src_valid;
   logic [SHW-1:0] ready;

   // Shift right into a double-width window so the upper half supplies the fill bits.
   function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                 input mode_e            m,
                                                 input logic             s,
                                                 input int unsigned      amt);
      logic [2*WIDTH-1:0] ext;
      logic [WIDTH-1:0]   res;
      ext = {{WIDTH{1'b0}}, d};
      case (m)
         MODE_SRA: ext[2*WIDTH-1:WIDTH] = {WIDTH{s}};
`ifdef ROTATE_EN
         MODE_ROR: ext[2*WIDTH-1:WIDTH] = d;
`endif
         default:  ;
      endcase
      ext = ext >> amt;
      res = (m == MODE_SLL) ? (d << amt) : ext[WIDTH-1:0];
      return res;
   endfunction

   // Stage k is ready unless it and every stage after it are full while the consumer stalls.
   // Written in closed form rather than as a chain so no signal feeds back on itself.
   always_comb begin
      logic all_full;
      // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
      ready = '0;
      for (int k = 0; k < SHW; k++) begin
         all_full = 1'b1;
         for (int j = k; j < SHW; j++) begin
            all_full = all_full & valid_q[j];
         end
         ready[k] = out_ready | ~all_full;
      end
   end

   always_comb begin
      src[0].data  = in;
      src[0].sel   = sel;
      src[0].mode  = mode_e'(mode);
      src[0].sign  = in[WIDTH-1];
      src_valid[0] = in_valid;
      for (int k = 1; k < SHW; k++) begin
         src[k]       = pay_q[k-1];
         src_valid[k] = valid_q[k-1];
      end
      for (int k = 0; k < SHW; k++) begin
         pay_d[k] = src[k];
         if (src[k].sel[k]) begin
            pay_d[k].data = shift_by(src[k].data, src[k].mode, src[k].sign, 1 << k);
         end
      end
   end

   // NOTE: stage data is reset along with the valid bits so out reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int k = 0; k < SHW; k++) begin
            pay_q[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep each stage reading its neighbour's old value.
         for (int k = 0; k < SHW; k++) begin
            if (ready[k]) begin
               valid_q[k] <= src_valid[k];
               if (src_valid[k]) begin
                  pay_q[k] <= pay_d[k];
               end
            end
         end
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_q[SHW-1];
   assign out       = pay_q[SHW-1].data;

   a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out)));

   a_ready_full : assert property (@(posedge clk) disable iff (!rst_n)
      !in_ready |-> (&valid_q && !out_ready));

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH=8); honours ROTATE_EN for mode 11 expectations.
module tb_barrel_shifter_pipe;

   localparam int W   = 8;
   localparam int SHW = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   din = '0;
   logic [SHW-1:0] sel_d = '0;
   logic [1:0]     mode_d = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   dout;

   typedef struct {
      logic [W-1:0] data;
      int           acc_cyc;
      int           lat_min;
      int           lat_max;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   toggle = 1'b0;

   barrel_shifter_pipe #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in       (din),
      .sel      (sel_d),
      .mode     (mode_d),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Bit-by-bit reference, deliberately unlike the RTL's window shift.
   function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic [1:0] m);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++) begin
         case (m)
            2'b00: r[i] = (i + s < W) ? d[(i + s) % W] : 1'b0;
            2'b01: r[i] = (i + s < W) ? d[(i + s) % W] : d[W-1];
            2'b10: r[i] = (i >= s) ? d[(i - s + W) % W] : 1'b0;
            default: begin
`ifdef ROTATE_EN
               r[i] = d[(i + s) % W];
`else
               r[i] = (i + s < W) ? d[(i + s) % W] : 1'b0;
`endif
            end
         endcase
      end
      return r;
   endfunction

   // Output monitor: a transfer seen before the edge completes on the next edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h, expected no output", dout);
         end else begin
            exp_t e;
            int   lat;
            e   = sb.pop_front();
            lat = cyc + 1 - e.acc_cyc;
            check("result", dout, e.data);
            if (e.lat_max != 0) begin
               n_checks++;
               if (lat < e.lat_min || lat > e.lat_max) begin
                  n_fail++;
                  $display("FAIL latency: got %0d, expected %0d..%0d", lat, e.lat_min, e.lat_max);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle) out_ready = ~out_ready;
   endtask

   task automatic send(input logic [W-1:0] d, input logic [SHW-1:0] s, input logic [1:0] m,
                       input logic [W-1:0] exp, input int lmin, input int lmax);
      din = d; sel_d = s; mode_d = m; in_valid = 1'b1;
      for (int t = 0; t <= 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{exp, cyc + 1, lmin, lmax});
            tick();
            return;
         end
         tick();
      end
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) tick();
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d results pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   logic [W-1:0]   st_in  [6] = '{8'h3C, 8'h80, 8'h01, 8'hC3, 8'h7F, 8'hF0};
   logic [SHW-1:0] st_sel [6] = '{3'd1, 3'd7, 3'd7, 3'd4, 3'd2, 3'd6};
   logic [1:0]     st_mod [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
`ifdef ROTATE_EN
   logic [W-1:0]   st_exp [6] = '{8'h1E, 8'hFF, 8'h80, 8'h3C, 8'h1F, 8'h03};
   localparam logic [W-1:0] B4_ROR = 8'h96;
`else
   logic [W-1:0]   st_exp [6] = '{8'h1E, 8'hFF, 8'h80, 8'h0C, 8'h1F, 8'h03};
   localparam logic [W-1:0] B4_ROR = 8'h16;
`endif

   initial begin
      int idx;
      logic [W-1:0]   rd;
      logic [SHW-1:0] rs;
      logic [1:0]     rm;

      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out", dout, 8'h00);
      check("reset_in_ready", in_ready, 1'b1);

      // Four modes back to back on 8'hB4 >> / << 3.
      send(8'hB4, 3'd3, 2'b00, 8'h16, SHW, SHW);
      send(8'hB4, 3'd3, 2'b01, 8'hF6, SHW, SHW);
      send(8'hB4, 3'd3, 2'b10, 8'hA0, SHW, SHW);
      send(8'hB4, 3'd3, 2'b11, B4_ROR, SHW, SHW);
      in_valid = 1'b0;
      drain();

      // Streaming: every result must arrive exactly SHW cycles after its accept.
      for (int i = 0; i < 20; i++) begin
         rd = W'($urandom);
         rs = SHW'($urandom_range(0, W - 1));
         rm = 2'($urandom_range(0, 3));
         send(rd, rs, rm, model(rd, int'(rs), rm), SHW, SHW);
      end
      in_valid = 1'b0;
      drain();

      // Consumer stall with continuous input: only SHW operands fit.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         din = st_in[idx]; sel_d = st_sel[idx]; mode_d = st_mod[idx];
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{st_exp[idx], cyc + 1, 0, 0});
            idx++;
         end
         tick();
      end
      check("stall_accepts", idx, 3);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_hold", dout, 8'h1E);
      out_ready = 1'b1;
      for (int i = idx; i < 6; i++) send(st_in[i], st_sel[i], st_mod[i], st_exp[i], 0, 0);
      in_valid = 1'b0;
      drain();

      // Lone operand, consumer ready every other cycle.
      toggle = 1'b1;
      send(8'h5A, 3'd5, 2'b10, 8'h40, SHW, SHW + 1);
      in_valid = 1'b0;
      repeat (8) tick();
      toggle = 1'b0;
      out_ready = 1'b1;
      drain();

      // Zero shift is identity in every mode.
      for (int m = 0; m < 4; m++) send(8'h81, 3'd0, 2'(m), 8'h81, SHW, SHW);
      in_valid = 1'b0;
      drain();

      // Reset with two operations in flight.
      send(8'hFF, 3'd1, 2'b00, 8'h7F, SHW, SHW);
      send(8'h0F, 3'd2, 2'b10, 8'h3C, SHW, SHW);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", out_valid, 1'b0);
      check("midreset_out", dout, 8'h00);
      sb.delete();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_reset_out_valid", out_valid, 1'b0);
         tick();
      end
      check("post_reset_in_ready", in_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
